// File: rtl/train_pkg.sv
// Shared point/signal indexing, FSM encodings and route-to-point decoding for point_sequencer.
package train_pkg;

  localparam int unsigned N_POINTS       = 6;
  localparam int unsigned N_SIGS         = 10;
  localparam int unsigned PT_X           = 0;
  localparam int unsigned PT_B           = 1;
  localparam int unsigned PT_C           = 2;
  localparam int unsigned SIDE_STRIDE    = 3;
  localparam int unsigned SIG_HOME_BASE  = 0;
  localparam int unsigned SIG_START_BASE = 2;
  localparam int unsigned TMR_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CANCEL,
    ST_CHECK,
    ST_PULSE,
    ST_GAP,
    ST_WAIT,
    ST_SIGNAL
  } state_t;

  // Points a route touches (mask) and the position each must be in (1 = reverse)
  typedef struct packed {
    logic [N_POINTS-1:0] mask;
    logic [N_POINTS-1:0] pos;
  } pt_req_t;

  // Decode a route into the required crossover and fan point positions
  function automatic pt_req_t req_points(input logic side, input logic dir,
                                         input logic [1:0] station);
    pt_req_t    r;
    logic [2:0] base;
    r    = '0;
    base = side ? 3'(SIDE_STRIDE) : 3'd0;
    r.mask[base + 3'(PT_X)] = 1'b1;
    r.pos[base + 3'(PT_X)]  = (dir == side) ? (station >= 2'd2) : (station <= 2'd1);
    if (station <= 2'd1) begin
      r.mask[base + 3'(PT_B)] = 1'b1;
      r.pos[base + 3'(PT_B)]  = station[0];
    end else begin
      r.mask[base + 3'(PT_C)] = 1'b1;
      r.pos[base + 3'(PT_C)]  = station[0];
    end
    return r;
  endfunction

  // Signal bit governing a route: home signal when inbound, starter when outbound
  function automatic logic [3:0] route_sig(input logic side, input logic dir,
                                           input logic [1:0] station);
    if (dir) return 4'(SIG_START_BASE) + {1'b0, side, station};
    return 4'(SIG_HOME_BASE) + {3'b000, side};
  endfunction

  // Every signal reading over the given throat
  function automatic logic [N_SIGS-1:0] throat_sigs(input logic side);
    logic [N_SIGS-1:0] m;
    m = '0;
    m[route_sig(side, 1'b0, 2'd0)] = 1'b1;
    for (int s = 0; s < 4; s++) m[route_sig(side, 1'b1, 2'(s))] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a zero flag; times coil pulses, recovery gaps and detection waits.
module pulse_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/point_sequencer.sv
// Route command sequencer: throws a route's points one solenoid pulse at a time, then clears its signal.
// Optional build macro POINT_FEEDBACK_EN: confirm each throw against point_det with a timeout fault.
module point_sequencer
  import train_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 10_000_000,
  parameter int unsigned GAP_CYCLES     = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_cancel,
  input  logic                req_side,
  input  logic                req_dir,
  input  logic [1:0]          req_station,
  input  logic [N_POINTS-1:0] point_det,
  output logic [N_POINTS-1:0] coil_normal,
  output logic [N_POINTS-1:0] coil_reverse,
  output logic [N_SIGS-1:0]   sig_clear,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

  state_t              state;
  logic                l_side;
  logic                l_dir;
  logic [1:0]          l_station;
  logic [N_POINTS-1:0] pos;
  logic [N_POINTS-1:0] pos_known;
  logic [2:0]          cur_pt;
  logic                cur_rev;

  pt_req_t             req_c;
  logic [N_POINTS-1:0] need_c;
  logic                any_c;
  logic [2:0]          pick_c;
  logic [3:0]          route_sig_c;
  logic                tmr_load_c;
  logic [TMR_W-1:0]    tmr_value_c;
  logic                tmr_zero_c;

  // Points still to throw for the latched route; X comes first, then the fan point
  always_comb begin
    req_c       = req_points(l_side, l_dir, l_station);
    need_c      = req_c.mask & (~pos_known | (pos ^ req_c.pos));
    any_c       = |need_c;
    route_sig_c = route_sig(l_side, l_dir, l_station);
    if (need_c[0])      pick_c = 3'd0;
    else if (need_c[1]) pick_c = 3'd1;
    else if (need_c[2]) pick_c = 3'd2;
    else if (need_c[3]) pick_c = 3'd3;
    else if (need_c[4]) pick_c = 3'd4;
    else                pick_c = 3'd5;
  end

`ifdef POINT_FEEDBACK_EN
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  logic fault_q;
  assign fault = fault_q;
`else
  logic unused_det;
  assign unused_det = ^{point_det, 32'(TIMEOUT_CYCLES)};
  assign fault      = 1'b0;
`endif

  // Timer reloads on entry to PULSE, GAP and (with feedback) WAIT
  always_comb begin
    tmr_load_c  = 1'b0;
    tmr_value_c = '0;
    if (state == ST_CHECK && any_c) begin
      tmr_load_c  = 1'b1;
      tmr_value_c = PULSE_LOAD;
    end else if (state == ST_PULSE && tmr_zero_c) begin
      tmr_load_c  = 1'b1;
      tmr_value_c = GAP_LOAD;
    end
`ifdef POINT_FEEDBACK_EN
    else if (state == ST_GAP && tmr_zero_c) begin
      tmr_load_c  = 1'b1;
      tmr_value_c = TIMEOUT_LOAD;
    end
`endif
  end

  pulse_timer #(.WIDTH(TMR_W)) u_timer (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .load       (tmr_load_c),
    .load_value (tmr_value_c),
    .zero_c     (tmr_zero_c)
  );

  // Sequencer FSM with registered coil, signal and handshake outputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      coil_normal  <= '0;
      coil_reverse <= '0;
      sig_clear    <= '0;
      pos          <= '0;
      pos_known    <= '0;
      l_side       <= 1'b0;
      l_dir        <= 1'b0;
      l_station    <= '0;
      cur_pt       <= '0;
      cur_rev      <= 1'b0;
`ifdef POINT_FEEDBACK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            l_side    <= req_side;
            l_dir     <= req_dir;
            l_station <= req_station;
            state     <= req_cancel ? ST_CANCEL : ST_CHECK;
          end
        end
        ST_CANCEL: begin
          sig_clear[route_sig_c] <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_CHECK: begin
          if (any_c) begin
            // Throat goes to danger in the same edge the first coil energises
            sig_clear <= sig_clear & ~throat_sigs(l_side);
            cur_pt    <= pick_c;
            cur_rev   <= req_c.pos[pick_c];
            if (req_c.pos[pick_c]) coil_reverse <= 6'b1 << pick_c;
            else                   coil_normal  <= 6'b1 << pick_c;
            state <= ST_PULSE;
          end else begin
            state <= ST_SIGNAL;
          end
        end
        ST_PULSE: begin
          if (tmr_zero_c) begin
            coil_normal  <= '0;
            coil_reverse <= '0;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero_c) begin
`ifdef POINT_FEEDBACK_EN
            state <= ST_WAIT;
`else
            pos[cur_pt]       <= cur_rev;
            pos_known[cur_pt] <= 1'b1;
            state             <= ST_CHECK;
`endif
          end
        end
`ifdef POINT_FEEDBACK_EN
        ST_WAIT: begin
          if (point_det[cur_pt] == cur_rev) begin
            pos[cur_pt]       <= point_det[cur_pt];
            pos_known[cur_pt] <= 1'b1;
            state             <= ST_CHECK;
          end else if (tmr_zero_c) begin
            fault_q           <= 1'b1;
            pos_known[cur_pt] <= 1'b0;
            busy              <= 1'b0;
            state             <= ST_IDLE;
          end
        end
`endif
        ST_SIGNAL: begin
          sig_clear[route_sig_c] <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_sequencer.sv
// Directed bench for point_sequencer with short pulse/gap/timeout counts.
module tb_point_sequencer;

  localparam int unsigned P = 4;
  localparam int unsigned G = 2;
  localparam int unsigned T = 8;
`ifdef POINT_FEEDBACK_EN
  localparam int FB = 1;
`else
  localparam int FB = 0;
`endif
  localparam int THROW = int'(P + G + 1) + FB;
  localparam logic [9:0] M0 = 10'b00_0011_1101;
  localparam logic [9:0] M1 = 10'b11_1100_0010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_cancel = 1'b0;
  logic       req_side = 1'b0;
  logic       req_dir = 1'b0;
  logic [1:0] req_station = 2'd0;
  logic [5:0] point_det = 6'd0;
  logic [5:0] coil_normal;
  logic [5:0] coil_reverse;
  logic [9:0] sig_clear;
  logic       busy;
  logic       done;
  logic       fault;
  logic       det_hold = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int hi_norm[6];
  int hi_rev[6];
  int seq[$];
  int lat;
  int done_cnt;
  int conflicts;
  int overlap;

  always #5 clk = ~clk;

  point_sequencer #(
    .PULSE_CYCLES   (P),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cancel   (req_cancel),
    .req_side     (req_side),
    .req_dir      (req_dir),
    .req_station  (req_station),
    .point_det    (point_det),
    .coil_normal  (coil_normal),
    .coil_reverse (coil_reverse),
    .sig_clear    (sig_clear),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  // Point detection follows the coils unless held at normal
  always @(posedge clk) begin
    if (det_hold) point_det <= 6'd0;
    else point_det <= (point_det | coil_reverse) & ~coil_normal;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic c, input logic s, input logic d, input logic [1:0] st);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    req_cancel  = c;
    req_side    = s;
    req_dir     = d;
    req_station = st;
    req_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic sample();
    logic [5:0] coil;
    coil = coil_normal | coil_reverse;
    for (int i = 0; i < 6; i++) begin
      if (coil_normal[i]) hi_norm[i]++;
      if (coil_reverse[i]) hi_rev[i]++;
    end
    if (seq.size() < 16) begin
      for (int i = 0; i < 6; i++) begin
        if (coil_normal[i] && hi_norm[i] == 1) seq.push_back(i);
        if (coil_reverse[i] && hi_rev[i] == 1) seq.push_back(10 + i);
      end
    end
    if ($countones(coil) > 1 || (coil_normal & coil_reverse) != 6'd0) overlap++;
    if ((|coil[2:0] && (sig_clear & M0) != 10'd0) || (|coil[5:3] && (sig_clear & M1) != 10'd0))
      conflicts++;
  endtask

  task automatic trace(input int budget);
    for (int i = 0; i < 6; i++) begin
      hi_norm[i] = 0;
      hi_rev[i]  = 0;
    end
    seq.delete();
    lat = 0; done_cnt = 0; conflicts = 0; overlap = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      lat++;
      sample();
      if (done) begin
        done_cnt++;
        break;
      end
    end
    repeat (2) begin
      @(negedge clk);
      sample();
      if (done) done_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    check_eq("rst_coils", 32'(coil_normal | coil_reverse), 32'd0);
    check_eq("rst_sig", 32'(sig_clear), 32'd0);
    check_eq("rst_busy_done", 32'({busy, done}), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1 check_eq("ready_first_cycle", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("ready_after", 32'(req_ready), 32'd1);

    // L, inbound, S3: X reverse then C normal, both unknown after reset
    issue(1'b0, 1'b0, 1'b0, 2'd2);
    trace(100);
    check_eq("t1_lat", 32'(lat), 32'(3 + 2 * THROW));
    check_eq("t1_npulses", 32'(seq.size()), 32'd2);
    if (seq.size() >= 2) begin
      check_eq("t1_first", 32'(seq[0]), 32'd10);
      check_eq("t1_second", 32'(seq[1]), 32'd2);
    end
    check_eq("t1_rev0_len", 32'(hi_rev[0]), 32'(P));
    check_eq("t1_norm2_len", 32'(hi_norm[2]), 32'(P));
    check_eq("t1_done", 32'(done_cnt), 32'd1);
    check_eq("t1_sig", 32'(sig_clear), 32'h001);
    check_eq("t1_safety", 32'(conflicts + overlap), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // Same route again: nothing to throw
    issue(1'b0, 1'b0, 1'b0, 2'd2);
    trace(50);
    check_eq("t2_lat", 32'(lat), 32'd3);
    check_eq("t2_npulses", 32'(seq.size()), 32'd0);
    check_eq("t2_sig", 32'(sig_clear), 32'h001);
    check_eq("t2_done", 32'(done_cnt), 32'd1);

    // L, outbound, S1: X already reversed, B to normal, home signal dropped
    issue(1'b0, 1'b0, 1'b1, 2'd0);
    trace(100);
    check_eq("t3_lat", 32'(lat), 32'(3 + THROW));
    check_eq("t3_npulses", 32'(seq.size()), 32'd1);
    if (seq.size() >= 1) check_eq("t3_coil", 32'(seq[0]), 32'd1);
    check_eq("t3_norm1_len", 32'(hi_norm[1]), 32'(P));
    check_eq("t3_safety", 32'(conflicts + overlap), 32'd0);
    check_eq("t3_sig", 32'(sig_clear), 32'h004);

    // Cancel R, inbound, S2 while its signal is already at danger
    issue(1'b1, 1'b1, 1'b0, 2'd1);
    trace(20);
    check_eq("t4_lat", 32'(lat), 32'd2);
    check_eq("t4_npulses", 32'(seq.size()), 32'd0);
    check_eq("t4_done", 32'(done_cnt), 32'd1);
    check_eq("t4_sig", 32'(sig_clear), 32'h004);

    // Reset in the middle of a right-throat pulse
    issue(1'b0, 1'b1, 1'b0, 2'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((coil_normal | coil_reverse) != 6'd0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t5_coil_seen", 32'(seen), 32'd1);
    check_eq("t5_left_sig_kept", 32'(sig_clear), 32'h004);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_coils", 32'(coil_normal | coil_reverse), 32'd0);
    check_eq("t5_rst_sig", 32'(sig_clear), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Same route after reset re-throws X and B
    issue(1'b0, 1'b1, 1'b0, 2'd1);
    trace(100);
    check_eq("t6_lat", 32'(lat), 32'(3 + 2 * THROW));
    check_eq("t6_npulses", 32'(seq.size()), 32'd2);
    if (seq.size() >= 2) begin
      check_eq("t6_first", 32'(seq[0]), 32'd13);
      check_eq("t6_second", 32'(seq[1]), 32'd14);
    end
    check_eq("t6_sig", 32'(sig_clear), 32'h002);

    // Cancel that route: home signal drops next cycle
    issue(1'b1, 1'b1, 1'b0, 2'd1);
    trace(20);
    check_eq("t7_lat", 32'(lat), 32'd2);
    check_eq("t7_sig", 32'(sig_clear), 32'd0);
    check_eq("t7_done", 32'(done_cnt), 32'd1);
    check_eq("fault_clear", 32'(fault), 32'd0);

`ifdef POINT_FEEDBACK_EN
    // L, inbound, S4: C to reverse with detection stuck at normal
    begin
      int fl;
      logic dn;
      fl = 0;
      dn = 1'b0;
      det_hold = 1'b1;
      issue(1'b0, 1'b0, 1'b0, 2'd3);
      for (int c = 1; c < 100; c++) begin
        @(negedge clk);
        if (done) dn = 1'b1;
        if (fault) begin
          fl = c;
          break;
        end
      end
      check_eq("fb_fault_lat", 32'(fl), 32'(2 + P + G + T));
      repeat (2) @(negedge clk);
      check_eq("fb_fault", 32'(fault), 32'd1);
      check_eq("fb_sig", 32'(sig_clear), 32'd0);
      check_eq("fb_ready", 32'(req_ready), 32'd1);
      check_eq("fb_no_done", 32'(dn), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
